// File: rtl/switch_allocator_pkg.sv
// Shared NoC router types and defaults for the switch allocator slice.
package pa_noc;

   localparam int NUM_PORTS    = 5;
   localparam int CREDIT_DEPTH = 4;
   localparam int IDX_W        = $clog2(NUM_PORTS);
   localparam int CRD_W        = $clog2(CREDIT_DEPTH + 1);

   typedef logic [IDX_W-1:0] port_idx_t;
   typedef logic [CRD_W-1:0] credit_t;

   // Successor of a port index on the round-robin ring.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/switch_allocator_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins (one-hot grant).
module round_robin_arbiter #(
   parameter int NUM_PORTS = pa_noc::NUM_PORTS,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] grant
);

   always_comb begin
      int   base;
      int   idx;
      logic found;
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      grant = '0;
      found = 1'b0;
      base  = (int'(ptr) < NUM_PORTS) ? int'(ptr) : 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = base + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && req[IDX_W'(idx)]) begin
            grant[IDX_W'(idx)] = 1'b1;
            found              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Credit-based separable switch allocator: one round-robin arbiter per output port.
// Optional sticky credit-overflow detection: define SWITCH_ALLOCATOR_CREDIT_CHECK_EN.
module switch_allocator #(
   parameter  int NUM_PORTS    = pa_noc::NUM_PORTS,
   parameter  int CREDIT_DEPTH = pa_noc::CREDIT_DEPTH,
   localparam int IDX_W        = $clog2(NUM_PORTS),
   localparam int CRD_W        = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic                            i_clk,
   input  logic                            i_srst,
   input  logic [NUM_PORTS-1:0]            i_reqValid,
   input  logic [NUM_PORTS-1:0][IDX_W-1:0] i_reqDest,
   input  logic [NUM_PORTS-1:0]            i_creditReturn,
   output logic [NUM_PORTS-1:0]            o_grant,
   output logic [NUM_PORTS-1:0]            o_outValid,
   output logic [NUM_PORTS-1:0][IDX_W-1:0] o_outSel,
   output logic [NUM_PORTS-1:0][CRD_W-1:0] o_credits,
   output logic                            o_creditError
);

   import pa_noc::*;

   localparam logic [CRD_W-1:0] FULL = CRD_W'(CREDIT_DEPTH);

   logic [NUM_PORTS-1:0][IDX_W-1:0]     rr_ptr;
   logic [NUM_PORTS-1:0][CRD_W-1:0]     credits;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_mat;   // [output][input]
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_mat;   // [output][input]
   logic [NUM_PORTS-1:0]                out_grant;
   logic [NUM_PORTS-1:0][IDX_W-1:0]     gnt_idx;
   logic [NUM_PORTS-1:0]                in_grant;

   // Out-of-range destinations match no output, so they never request anything.
   always_comb begin
      req_mat = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            req_mat[o][i] = i_reqValid[i] && (int'(i_reqDest[i]) == o) && (credits[o] != '0);
         end
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
      round_robin_arbiter #(
         .NUM_PORTS (NUM_PORTS),
         .IDX_W     (IDX_W)
      ) u_arb (
         .req   (req_mat[o]),
         .ptr   (rr_ptr[o]),
         .grant (gnt_mat[o])
      );
   end

   always_comb begin
      out_grant = '0;
      gnt_idx   = '0;
      in_grant  = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         out_grant[o] = |gnt_mat[o];
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_mat[o][i]) begin
               gnt_idx[o]  = IDX_W'(i);
               in_grant[i] = 1'b1;
            end
         end
      end
   end

   // Reset masks the transfer outright; the state update below ignores it too.
   always_comb begin
      o_grant    = i_srst ? '0 : in_grant;
      o_outValid = i_srst ? '0 : out_grant;
      o_outSel   = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (o_outValid[o]) o_outSel[o] = gnt_idx[o];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         // NOTE: nonblocking assignments keep every register update order-independent.
         credits <= {NUM_PORTS{FULL}};
         rr_ptr  <= '0;
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (out_grant[o]) rr_ptr[o] <= IDX_W'(wrap_inc(int'(gnt_idx[o]), NUM_PORTS));
            if (out_grant[o] && !i_creditReturn[o]) begin
               credits[o] <= credits[o] - CRD_W'(1);
            end else if (!out_grant[o] && i_creditReturn[o] && credits[o] != FULL) begin
               credits[o] <= credits[o] + CRD_W'(1);
            end
         end
      end
   end

   assign o_credits = credits;

`ifdef SWITCH_ALLOCATOR_CREDIT_CHECK_EN
   logic [NUM_PORTS-1:0] overflow;
   logic                 credit_error;

   always_comb begin
      overflow = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         overflow[o] = i_creditReturn[o] && !out_grant[o] && (credits[o] == FULL);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_srst)         credit_error <= 1'b0;
      else if (|overflow) credit_error <= 1'b1;
   end

   assign o_creditError = credit_error;
`else
   assign o_creditError = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed-vector bench for switch_allocator: a stimulus table plus hand-written reset/credit sequences.
module tb_switch_allocator;

   import pa_noc::*;

   localparam int N = NUM_PORTS;

`ifdef SWITCH_ALLOCATOR_CREDIT_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                srst;
   logic [N-1:0]        req_valid;
   port_idx_t [N-1:0]   req_dest;
   logic [N-1:0]        credit_return;
   logic [N-1:0]        grant;
   logic [N-1:0]        out_valid;
   port_idx_t [N-1:0]   out_sel;
   credit_t [N-1:0]     credits;
   logic                credit_error;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   switch_allocator dut (
      .i_clk          (clk),
      .i_srst         (srst),
      .i_reqValid     (req_valid),
      .i_reqDest      (req_dest),
      .i_creditReturn (credit_return),
      .o_grant        (grant),
      .o_outValid     (out_valid),
      .o_outSel       (out_sel),
      .o_credits      (credits),
      .o_creditError  (credit_error)
   );

   typedef struct {
      logic [N-1:0]      valid;
      logic [3*N-1:0]    dest;
      logic [N-1:0]      ret;
      logic [N-1:0]      exp_grant;
      logic [N-1:0]      exp_ov;
      logic [3*N-1:0]    exp_sel;
      logic [3*N-1:0]    exp_cr;
   } vec_t;

   vec_t vecs[19];

   function automatic logic [3*N-1:0] p5(input int a0, input int a1, input int a2,
                                         input int a3, input int a4);
      return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      srst          = 1'b1;
      req_valid     = '0;
      credit_return = '0;
      @(negedge clk);
      srst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Sequential table: each row is checked before its clock edge, state carries forward.
      //                 valid     dest            ret       grant     outValid  sel             credits
      vecs[0]  = '{5'b00101, p5(1,0,1,0,0), 5'b00000, 5'b00001, 5'b00010, p5(0,0,0,0,0), p5(4,4,4,4,4)};
      vecs[1]  = '{5'b00101, p5(1,0,1,0,0), 5'b00000, 5'b00100, 5'b00010, p5(0,2,0,0,0), p5(4,3,4,4,4)};
      vecs[2]  = '{5'b00101, p5(1,0,1,0,0), 5'b00000, 5'b00001, 5'b00010, p5(0,0,0,0,0), p5(4,2,4,4,4)};
      vecs[3]  = '{5'b00000, p5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, p5(0,0,0,0,0), p5(4,1,4,4,4)};
      vecs[4]  = '{5'b00010, p5(0,3,0,0,0), 5'b00000, 5'b00010, 5'b01000, p5(0,0,0,1,0), p5(4,1,4,4,4)};
      vecs[5]  = '{5'b00010, p5(0,3,0,0,0), 5'b00000, 5'b00010, 5'b01000, p5(0,0,0,1,0), p5(4,1,4,3,4)};
      vecs[6]  = '{5'b00010, p5(0,3,0,0,0), 5'b00000, 5'b00010, 5'b01000, p5(0,0,0,1,0), p5(4,1,4,2,4)};
      vecs[7]  = '{5'b00010, p5(0,3,0,0,0), 5'b00000, 5'b00010, 5'b01000, p5(0,0,0,1,0), p5(4,1,4,1,4)};
      vecs[8]  = '{5'b00010, p5(0,3,0,0,0), 5'b01000, 5'b00000, 5'b00000, p5(0,0,0,0,0), p5(4,1,4,0,4)};
      vecs[9]  = '{5'b00010, p5(0,3,0,0,0), 5'b00000, 5'b00010, 5'b01000, p5(0,0,0,1,0), p5(4,1,4,1,4)};
      vecs[10] = '{5'b00000, p5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, p5(0,0,0,0,0), p5(4,1,4,0,4)};
      vecs[11] = '{5'b00001, p5(2,0,0,0,0), 5'b00000, 5'b00001, 5'b00100, p5(0,0,0,0,0), p5(4,1,4,0,4)};
      vecs[12] = '{5'b00001, p5(2,0,0,0,0), 5'b00000, 5'b00001, 5'b00100, p5(0,0,0,0,0), p5(4,1,3,0,4)};
      vecs[13] = '{5'b00001, p5(2,0,0,0,0), 5'b00100, 5'b00001, 5'b00100, p5(0,0,0,0,0), p5(4,1,2,0,4)};
      vecs[14] = '{5'b00000, p5(0,0,0,0,0), 5'b01000, 5'b00000, 5'b00000, p5(0,0,0,0,0), p5(4,1,2,0,4)};
      vecs[15] = '{5'b11111, p5(1,2,3,4,0), 5'b00000, 5'b11111, 5'b11111, p5(4,0,1,2,3), p5(4,1,2,1,4)};
      vecs[16] = '{5'b00000, p5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, p5(0,0,0,0,0), p5(3,0,1,0,3)};
      vecs[17] = '{5'b00111, p5(5,7,0,0,0), 5'b00000, 5'b00100, 5'b00001, p5(2,0,0,0,0), p5(3,0,1,0,3)};
      vecs[18] = '{5'b00000, p5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, p5(0,0,0,0,0), p5(2,0,1,0,3)};

      srst          = 1'b1;
      req_valid     = 5'b00001;
      req_dest      = '0;
      credit_return = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset grant forced 0", 32'(grant), 32'd0);
      check("reset outValid forced 0", 32'(out_valid), 32'd0);
      check("reset credits", 32'(credits), 32'(p5(4,4,4,4,4)));
      check("reset creditError", 32'(credit_error), 32'd0);

      for (int k = 0; k < 19; k++) begin
         @(negedge clk);
         srst          = 1'b0;
         req_valid     = vecs[k].valid;
         req_dest      = vecs[k].dest;
         credit_return = vecs[k].ret;
         #1;
         check($sformatf("v%0d grant", k),    32'(grant),     32'(vecs[k].exp_grant));
         check($sformatf("v%0d outValid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
         check($sformatf("v%0d outSel", k),   32'(out_sel),   32'(vecs[k].exp_sel));
         check($sformatf("v%0d credits", k),  32'(credits),   32'(vecs[k].exp_cr));
      end

      // Credit return at full credit: flag (when enabled) is sticky, credits saturate.
      do_reset();
      credit_return = 5'b00001;
      #1;
      check("ovf pre creditError", 32'(credit_error), 32'd0);
      check("ovf pre credits0", 32'(credits[0]), 32'd4);
      @(negedge clk);
      credit_return = '0;
      #1;
      check("ovf creditError set", 32'(credit_error), 32'(EXP_ERR));
      check("ovf credits0 saturated", 32'(credits[0]), 32'd4);
      @(negedge clk);
      #1;
      check("ovf creditError held", 32'(credit_error), 32'(EXP_ERR));
      do_reset();
      #1;
      check("ovf creditError cleared", 32'(credit_error), 32'd0);

      // Reset while input 4 would be granted on output 0 with one credit left.
      req_valid     = 5'b00010;
      req_dest      = p5(0,0,0,0,0);
      repeat (3) @(negedge clk);
      srst      = 1'b1;
      req_valid = 5'b10000;
      #1;
      check("rst-mid credits0 before", 32'(credits[0]), 32'd1);
      check("rst-mid grant suppressed", 32'(grant), 32'd0);
      check("rst-mid outValid suppressed", 32'(out_valid), 32'd0);
      @(negedge clk);
      srst      = 1'b0;
      req_valid = 5'b10010;
      #1;
      check("rst-mid credits0 restored", 32'(credits[0]), 32'd4);
      check("rst-mid ptr0 back to 0", 32'(grant), 32'b00010);
      check("rst-mid outSel0", 32'(out_sel[0]), 32'd1);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("rst-mid credits0 after grant", 32'(credits[0]), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
